processor: RTL and testbench
============================

Name: processor

Overview:
- Single-cycle RV32I-subset CPU; one instruction retires per clock.
- Built-in instruction ROM holds a fixed boot program. Internal data RAM is the only architectural output.
- Top-level block with no bus ports; verification reads state through hierarchical paths.
- Boot program computes 25 and stores it to data word 0.

Parameters:
- IMEM_WORDS, 64, instruction ROM depth in 32-bit words; PC wraps modulo this depth.
- DMEM_WORDS, 64, data RAM depth in 32-bit words; byte addresses use bits [log2(DMEM_WORDS)+1:2].

Ports:
- clk  input  1  single rising-edge clock for all state.
- reset  input  1  synchronous, active-high; sampled on rising clk.

Behaviour:
- Hierarchy, mandatory for the bench:
  - Data RAM instance is named `memory`; its word array is named `memory` (so `memory.memory[i]` is word i).
  - Register file instance is named `regfile`; its array is named `regs`.
- Reset (sync, active-high): PC=0; x1..x31=0; every data RAM word=0. No instruction retires in a reset cycle.
- Each non-reset edge commits the current instruction:
  - rd write and/or RAM write.
  - PC update: PC+4, branch/jump target, or hold when halted.
- x0 reads 0 always; writes to x0 are discarded.
- Register reads are combinational. Register write is at the edge, so no bypass is needed.
- Supported instructions:
  - R-type: ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA.
  - I-type: ADDI, ANDI, ORI, XORI, SLTI, SLLI, SRLI, SRAI.
  - Memory: LW, SW.
  - Branch: BEQ, BNE, BLT, BGE.
  - Jump: JAL, JALR (JALR clears target bit 0).
  - Upper: LUI, AUIPC.
- Immediates are sign-extended per RV32I format. Arithmetic is 32-bit wrap-around. Shift amount is the low 5 bits.
- LW/SW are word access only:
  - Address bits [1:0] are ignored.
  - Address is taken modulo DMEM_WORDS.
  - LW data is read combinationally.
  - SW writes at the edge.
- Any other opcode, including 0x00000000, executes as a NOP: no writes, PC+4.
- Instruction ROM contents (word index: instruction):
  - 0: ADDI x1,x0,5
  - 1: ADD x2,x1,x1 (x2=10)
  - 2: ADD x3,x2,x2 (x3=20)
  - 3: ADD x4,x3,x1 (x4=25)
  - 4: SW x4,0(x0)
  - 5: EBREAK
  - 6: JAL x0,0 (self-loop)
  - remaining words: 0.
- Timing:
  - memory[0]=25 after the 5th post-reset rising edge.
  - State stays stable from then on: halt or self-loop.
- Reset asserted mid-program: restart at PC=0 on that edge, with registers and RAM cleared.
- PC beyond ROM depth wraps modulo IMEM_WORDS.

Optional Feature:
- Macro: PROCESSOR_HALT_EN.
- Defined:
  - SYSTEM opcode 0x73 (EBREAK/ECALL) sets an internal `halted` flag at the edge.
  - While halted: PC frozen, no register or RAM writes.
  - Only reset clears `halted`.
- Undefined:
  - 0x73 is a NOP with PC+4.
  - Boot program then reaches word 6 and self-loops.
- Architectural results are identical in both builds.

Test Plan:
- Reset then 10 cycles → memory.memory[0]==25; regs[1..4]==5,10,20,25; memory.memory[1]==0.
- Hold reset 3 cycles → PC==0, all regs==0, all RAM==0; no writes while reset is high.
- Assert reset for 1 cycle after 3 instructions, then release → regs clear; memory[0]==25 again exactly 5 edges after release.
- Run 50 cycles → PC stable:
  - with PROCESSOR_HALT_EN: 0x14.
  - without PROCESSOR_HALT_EN: 0x18.
  - memory[0] still 25.
- ROM override per build, exercising SUB, SLT, SRA, BNE, JAL link and LW-after-SW:
  - ADDI x5,x0,-8; SRAI x6,x5,1 → x6==0xFFFFFFFC.
  - BNE taken skips the next instruction.
  - JAL x1 writes PC+4 into x1.
- Write to x0 (ADDI x0,x0,7) → regs[0] reads 0 in every cycle.

Source files
------------

// File: rtl/processor.sv
// Single-cycle RV32I-subset CPU with a built-in boot ROM and an internal data RAM.
// The boot program computes 25 and stores it to data word 0.
// Optional build macro PROCESSOR_HALT_EN: SYSTEM opcode (0x73) latches a halted
// flag that freezes the PC and suppresses all writes until reset.

module regfile (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);
   logic [31:0] regs [32];

   // Clear on reset; x0 is never written so it stays zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (we && wa != 5'd0) begin
         regs[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
   assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];
endmodule

module data_ram #(
   parameter int WORDS = 64,
   parameter int AW    = $clog2(WORDS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] idx,
   input  logic [31:0]   wd,
   output logic [31:0]   rd
);
   logic [31:0] memory [WORDS];

   // Whole array clears on reset; stores land at the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < WORDS; i++) memory[i] <= '0;
      end else if (we) begin
         memory[idx] <= wd;
      end
   end

   assign rd = memory[idx];
endmodule

module processor #(
   parameter int IMEM_WORDS = 64,
   parameter int DMEM_WORDS = 64,
   parameter logic [IMEM_WORDS*32-1:0] ROM_IMAGE = {
      {(IMEM_WORDS-7)*32{1'b0}},
      32'h0000006F,   // 6: JAL  x0,0
      32'h00100073,   // 5: EBREAK
      32'h00402023,   // 4: SW   x4,0(x0)
      32'h00118233,   // 3: ADD  x4,x3,x1
      32'h002101B3,   // 2: ADD  x3,x2,x2
      32'h00108133,   // 1: ADD  x2,x1,x1
      32'h00500093    // 0: ADDI x1,x0,5
   }
) (
   input logic clk,
   input logic reset
);
   localparam int IAW = $clog2(IMEM_WORDS);
   localparam int DAW = $clog2(DMEM_WORDS);
   localparam logic [31:0] PC_MASK = 32'(IMEM_WORDS*4 - 1);

   logic [31:0]    pc, pc_next, instr, rs1_val, rs2_val, rf_wd, ram_rd, mem_addr;
   logic [IAW-1:0] fetch_idx;
   logic [DAW-1:0] ram_idx;
   logic           rf_we, ram_we, stall, taken;
   logic [6:0]     opcode;
   logic [2:0]     f3;
   logic [31:0]    imm_i, imm_s, imm_b, imm_u, imm_j;

   assign fetch_idx = IAW'(pc >> 2);
   assign instr     = ROM_IMAGE[32*fetch_idx +: 32];
   assign opcode    = instr[6:0];
   assign f3        = instr[14:12];
   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'b0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] op, input logic alt);
      case (op)
         3'd0:    alu = alt ? a - b : a + b;
         3'd1:    alu = a << b[4:0];
         3'd2:    alu = {31'b0, $signed(a) < $signed(b)};
         3'd3:    alu = {31'b0, a < b};
         3'd4:    alu = a ^ b;
         3'd5:    alu = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'd6:    alu = a | b;
         default: alu = a & b;
      endcase
   endfunction

   regfile regfile (
      .clk(clk), .reset(reset), .we(rf_we && !stall),
      .ra1(instr[19:15]), .ra2(instr[24:20]), .wa(instr[11:7]),
      .wd(rf_wd), .rd1(rs1_val), .rd2(rs2_val)
   );

   // Word index: byte address bits [1:0] dropped, then modulo the RAM depth.
   assign mem_addr = rs1_val + ((opcode == 7'h23) ? imm_s : imm_i);
   assign ram_idx  = DAW'(mem_addr >> 2);

   data_ram #(.WORDS(DMEM_WORDS)) memory (
      .clk(clk), .reset(reset), .we(ram_we && !stall),
      .idx(ram_idx), .wd(rs2_val), .rd(ram_rd)
   );

   // Branch condition from funct3.
   always_comb begin
      case (f3)
         3'd0:    taken = rs1_val == rs2_val;
         3'd1:    taken = rs1_val != rs2_val;
         3'd4:    taken = $signed(rs1_val) <  $signed(rs2_val);
         3'd5:    taken = $signed(rs1_val) >= $signed(rs2_val);
         3'd6:    taken = rs1_val <  rs2_val;
         3'd7:    taken = rs1_val >= rs2_val;
         default: taken = 1'b0;
      endcase
   end

   // Decode/execute: write-back value, write enables and next PC.
   always_comb begin
      rf_we   = 1'b0;
      rf_wd   = '0;
      ram_we  = 1'b0;
      pc_next = pc + 32'd4;
      case (opcode)
         7'h33: begin rf_we = 1'b1; rf_wd = alu(rs1_val, rs2_val, f3, instr[30]); end
         7'h13: begin rf_we = 1'b1; rf_wd = alu(rs1_val, imm_i, f3, f3 == 3'd5 && instr[30]); end
         7'h03: begin rf_we = 1'b1; rf_wd = ram_rd; end
         7'h23: ram_we = 1'b1;
         7'h63: if (taken) pc_next = pc + imm_b;
         7'h6F: begin rf_we = 1'b1; rf_wd = pc + 32'd4; pc_next = pc + imm_j; end
         7'h67: begin rf_we = 1'b1; rf_wd = pc + 32'd4; pc_next = (rs1_val + imm_i) & ~32'd1; end
         7'h37: begin rf_we = 1'b1; rf_wd = imm_u; end
         7'h17: begin rf_we = 1'b1; rf_wd = pc + imm_u; end
`ifdef PROCESSOR_HALT_EN
         7'h73: pc_next = pc;
`endif
         default: ;
      endcase
   end

`ifdef PROCESSOR_HALT_EN
   logic halted;

   // Sticky halt on SYSTEM opcode; only reset clears it.
   always_ff @(posedge clk) begin
      if (reset)                  halted <= 1'b0;
      else if (opcode == 7'h73)   halted <= 1'b1;
   end
   assign stall = halted;
`else
   assign stall = 1'b0;
`endif

   // PC register; wraps within the ROM's byte range.
   always_ff @(posedge clk) begin
      if (reset)       pc <= '0;
      else if (!stall) pc <= pc_next & PC_MASK;
   end
endmodule

// File: tb/tb_processor.sv
// Bench for processor: boot-ROM DUT plus an alternate-ROM DUT, both checked
// against an instruction-level reference model, with directed and random resets.
module tb_processor;
   localparam logic [2047:0] BOOT = {
      {57*32{1'b0}},
      32'h0000006F, 32'h00100073, 32'h00402023, 32'h00118233,
      32'h002101B3, 32'h00108133, 32'h00500093
   };
   localparam logic [2047:0] PROG_B = {
      {46*32{1'b0}},
      32'h00000063, 32'h00088867, 32'h04500893, 32'h00001797,   // 17..14
      32'h12345737, 32'h0072B6B3, 32'h00700013, 32'h00402603,   // 13..10
      32'h00802223, 32'h00100593, 32'h008000EF, 32'h06300513,   //  9..6
      32'h00049463, 32'h0072A4B3, 32'h40538433, 32'h00300393,   //  5..2
      32'h4012D313, 32'hFF800293                                //  1..0
   };
`ifdef PROCESSOR_HALT_EN
   localparam logic [31:0] END_PC = 32'h14;
`else
   localparam logic [31:0] END_PC = 32'h18;
`endif

   logic clk = 1'b0;
   logic rst_a, rst_b;
   int   checks = 0, failures = 0;

   always #5 clk = ~clk;

   processor dut_a (.clk(clk), .reset(rst_a));
   processor #(.ROM_IMAGE(PROG_B)) dut_b (.clk(clk), .reset(rst_b));

   logic [31:0] rom   [2][64];
   logic [31:0] m_pc  [2];
   logic [31:0] m_x   [2][32];
   logic [31:0] m_mem [2][64];
   bit          m_halt[2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One architectural step of the reference ISS for machine d.
   task automatic model_step(input int d, input bit rst);
      logic [31:0] ins, a, b, ii, si, bi, ji, res, nxt;
      logic [6:0]  op;
      logic [2:0]  fn;
      int          sh, rd;
      bit          wr, cond;
      if (rst) begin
         m_pc[d] = 0; m_halt[d] = 0;
         for (int i = 0; i < 32; i++) m_x[d][i] = 0;
         for (int i = 0; i < 64; i++) m_mem[d][i] = 0;
         return;
      end
      if (m_halt[d]) return;
      ins = rom[d][(m_pc[d] / 4) % 64];
      op = ins[6:0]; fn = ins[14:12]; rd = int'(ins[11:7]);
      a  = m_x[d][ins[19:15]];
      b  = m_x[d][ins[24:20]];
      ii = {{20{ins[31]}}, ins[31:20]};
      si = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      bi = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      ji = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      nxt = m_pc[d] + 4; wr = 0; res = 0;
      if (op == 7'h33 || op == 7'h13) begin
         if (op == 7'h13) b = ii;
         sh = int'(b % 32);
         wr = 1;
         case (fn)
            0: res = (op == 7'h33 && ins[30]) ? a - b : a + b;
            1: res = a << sh;
            2: res = (int'(a) < int'(b)) ? 1 : 0;
            3: res = (a < b) ? 1 : 0;
            4: res = a ^ b;
            5: res = (a >> sh) | ((ins[30] && a[31]) ? ~(32'hFFFFFFFF >> sh) : 0);
            6: res = a | b;
            7: res = a & b;
         endcase
      end else if (op == 7'h03) begin
         wr = 1; res = m_mem[d][((a + ii) / 4) % 64];
      end else if (op == 7'h23) begin
         m_mem[d][((a + si) / 4) % 64] = b;
      end else if (op == 7'h63) begin
         case (fn)
            0: cond = a == b;
            1: cond = a != b;
            4: cond = int'(a) <  int'(b);
            5: cond = int'(a) >= int'(b);
            6: cond = a <  b;
            7: cond = a >= b;
            default: cond = 0;
         endcase
         if (cond) nxt = m_pc[d] + bi;
      end else if (op == 7'h6F) begin
         wr = 1; res = m_pc[d] + 4; nxt = m_pc[d] + ji;
      end else if (op == 7'h67) begin
         wr = 1; res = m_pc[d] + 4; nxt = (a + ii) & 32'hFFFFFFFE;
      end else if (op == 7'h37) begin
         wr = 1; res = {ins[31:12], 12'h000};
      end else if (op == 7'h17) begin
         wr = 1; res = m_pc[d] + {ins[31:12], 12'h000};
      end
`ifdef PROCESSOR_HALT_EN
      if (op == 7'h73) begin m_halt[d] = 1; nxt = m_pc[d]; end
`endif
      if (wr && rd != 0) m_x[d][rd] = res;
      m_pc[d] = nxt % 256;
   endtask

   task automatic compare_all();
      chk("a.pc", dut_a.pc, m_pc[0]);
      chk("b.pc", dut_b.pc, m_pc[1]);
      for (int i = 0; i < 32; i++) begin
         chk($sformatf("a.x%0d", i), dut_a.regfile.regs[i], m_x[0][i]);
         chk($sformatf("b.x%0d", i), dut_b.regfile.regs[i], m_x[1][i]);
      end
      for (int i = 0; i < 64; i++) begin
         chk($sformatf("a.mem%0d", i), dut_a.memory.memory[i], m_mem[0][i]);
         chk($sformatf("b.mem%0d", i), dut_b.memory.memory[i], m_mem[1][i]);
      end
   endtask

   task automatic cycle(input bit ra, input bit rb);
      rst_a = ra; rst_b = rb;
      @(posedge clk); #1;
      model_step(0, ra);
      model_step(1, rb);
      compare_all();
   endtask

   initial begin
      for (int w = 0; w < 64; w++) begin
         rom[0][w] = BOOT[w*32 +: 32];
         rom[1][w] = PROG_B[w*32 +: 32];
      end
      rst_a = 1'b1; rst_b = 1'b1;

      // Reset held for three edges.
      repeat (3) cycle(1, 1);
      chk("rst.pc", dut_a.pc, 32'h0);

      // Boot program result after 10 edges.
      repeat (10) cycle(0, 0);
      chk("boot.mem0", dut_a.memory.memory[0], 32'd25);
      chk("boot.mem1", dut_a.memory.memory[1], 32'd0);
      chk("boot.x1", dut_a.regfile.regs[1], 32'd5);
      chk("boot.x2", dut_a.regfile.regs[2], 32'd10);
      chk("boot.x3", dut_a.regfile.regs[3], 32'd20);
      chk("boot.x4", dut_a.regfile.regs[4], 32'd25);

      // Mid-program reset: restart and hit the store exactly 5 edges later.
      cycle(1, 1);
      repeat (3) cycle(0, 0);
      cycle(1, 1);
      chk("mid.x1", dut_a.regfile.regs[1], 32'd0);
      chk("mid.mem0", dut_a.memory.memory[0], 32'd0);
      repeat (4) cycle(0, 0);
      chk("mid.mem0_e4", dut_a.memory.memory[0], 32'd0);
      cycle(0, 0);
      chk("mid.mem0_e5", dut_a.memory.memory[0], 32'd25);

      // Long run: stable end state.
      repeat (50) cycle(0, 0);
      chk("end.pc", dut_a.pc, END_PC);
      chk("end.mem0", dut_a.memory.memory[0], 32'd25);

      // Alternate program results.
      chk("b.srai", dut_b.regfile.regs[6], 32'hFFFFFFFC);
      chk("b.sub", dut_b.regfile.regs[8], 32'd11);
      chk("b.slt", dut_b.regfile.regs[9], 32'd1);
      chk("b.bne_skip", dut_b.regfile.regs[10], 32'd0);
      chk("b.jal_skip", dut_b.regfile.regs[11], 32'd0);
      chk("b.jal_link", dut_b.regfile.regs[1], 32'h20);
      chk("b.sw", dut_b.memory.memory[1], 32'd11);
      chk("b.lw", dut_b.regfile.regs[12], 32'd11);
      chk("b.x0", dut_b.regfile.regs[0], 32'd0);
      chk("b.sltu", dut_b.regfile.regs[13], 32'd0);
      chk("b.lui", dut_b.regfile.regs[14], 32'h12345000);
      chk("b.auipc", dut_b.regfile.regs[15], 32'h1038);
      chk("b.jalr_link", dut_b.regfile.regs[16], 32'h44);
      chk("b.jalr_pc", dut_b.pc, 32'h44);

      // Random reset pulses against the model.
      for (int c = 0; c < 400; c++)
         cycle($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
